// File: rtl/ready_level_monitor.sv
// ready_level_monitor: synchronise, qualify and fault-check a source's ready level
//  Ports: clk, rst_n (async active-low); sig_in (async level); clr (sync fault clear / restart);
//  sig_ready (1 in READY); fault_timeout, fault_drop (sticky); state_o (WAIT=00 QUAL=01 READY=10 FAULT=11);
//  drop_cnt (abort/drop count, only built with READY_MON_DROP_CNT_EN, else tied to 0).
module ready_level_monitor #(
  parameter int QUAL_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic             sig_ready,
  output logic             fault_timeout,
  output logic             fault_drop,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  typedef enum logic [1:0] {WAIT = 2'b00, QUAL = 2'b01, READY = 2'b10, FAULT = 2'b11} state_t;
  state_t state;
  logic s1, sig_s;
  logic [TW-1:0] tmo_cnt;
  logic [QW-1:0] qual_cnt;
  logic counting, qualify, timeout, abort, drop;
  assign counting = (state == WAIT) || (state == QUAL);
  assign qualify  = (state == QUAL) && sig_s && (qual_cnt == QW'(QUAL_CYCLES - 1));
  assign timeout  = counting && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) && !qualify;
  assign abort    = (state == QUAL) && !sig_s && !timeout;
  assign drop     = (state == READY) && !sig_s;
  assign state_o  = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1            <= 1'b0;
      sig_s         <= 1'b0;
      state         <= WAIT;
      tmo_cnt       <= '0;
      qual_cnt      <= '0;
      sig_ready     <= 1'b0;
      fault_timeout <= 1'b0;
      fault_drop    <= 1'b0;
    end else begin
      s1    <= sig_in;
      sig_s <= s1;
      if (clr) begin
        state         <= WAIT;
        tmo_cnt       <= '0;
        qual_cnt      <= '0;
        sig_ready     <= 1'b0;
        fault_timeout <= 1'b0;
        fault_drop    <= 1'b0;
      end else if (qualify) begin
        state     <= READY;
        tmo_cnt   <= '0;
        sig_ready <= 1'b1;
      end else if (timeout) begin
        state         <= FAULT;
        tmo_cnt       <= '0;
        fault_timeout <= 1'b1;
      end else if (drop) begin
        state      <= FAULT;
        fault_drop <= 1'b1;
        sig_ready  <= 1'b0;
      end else if (counting) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (abort) state <= WAIT;
        else if (state == WAIT && sig_s) begin
          state    <= QUAL;
          qual_cnt <= '0;
        end else if (state == QUAL) qual_cnt <= qual_cnt + 1'b1;
      end
    end
`ifdef READY_MON_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (!clr && (abort || drop) && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_ready_level_monitor.sv
// tb_ready_level_monitor: randomized and directed bench with a run-length reference model
module tb_ready_level_monitor;
  localparam int Q = 16, T = 1024, CW = 8;
  logic clk = 0, rst_n = 0, sig_in = 0, clr = 0, sig6 = 0;
  logic sig_ready, fault_timeout, fault_drop;
  logic [1:0] state_o;
  logic [CW-1:0] drop_cnt;
  logic r6, ft6, fd6;
  logic [1:0] st6;
  logic [CW-1:0] dc6;
  int passed = 0, total = 0;
  int phase, run, elapsed, drops, n;
  bit f_to, f_drop;
  bit hist[$];
  always #5 clk = ~clk;
  ready_level_monitor #(.QUAL_CYCLES(Q), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr), .sig_ready(sig_ready),
    .fault_timeout(fault_timeout), .fault_drop(fault_drop), .state_o(state_o), .drop_cnt(drop_cnt));
  ready_level_monitor #(.QUAL_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_W(CW)) u6 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig6), .clr(1'b0), .sig_ready(r6),
    .fault_timeout(ft6), .fault_drop(fd6), .state_o(st6), .drop_cnt(dc6));
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    else passed++;
  endtask
  task automatic m_reset();
    phase = 0; run = 0; elapsed = 0; drops = 0; f_to = 0; f_drop = 0;
    hist = '{1'b0, 1'b0};
  endtask
  task automatic bump();
    if (drops < (1 << CW) - 1) drops++;
  endtask
  task automatic model_step();
    bit s;
    int nr;
    s = hist.pop_front();
    hist.push_back(sig_in);
    if (clr) begin
      phase = 0; run = 0; elapsed = 0; f_to = 0; f_drop = 0;
    end else if (phase == 0) begin
      elapsed++;
      nr = s ? run + 1 : 0;
      if (nr == Q + 1) begin phase = 1; run = 0; elapsed = 0; end
      else if (elapsed == T) begin phase = 2; f_to = 1; run = 0; elapsed = 0; end
      else begin
        if (run > 0 && !s) bump();
        run = nr;
      end
    end else if (phase == 1 && !s) begin
      phase = 2; f_drop = 1; bump();
    end
  endtask
  function automatic logic [4:0] exp_out();
    logic [1:0] st;
    st = phase == 0 ? (run > 0 ? 2'b01 : 2'b00) : phase == 1 ? 2'b10 : 2'b11;
    return {phase == 1, f_to, f_drop, st};
  endfunction
  function automatic logic [CW-1:0] exp_drops();
`ifdef READY_MON_DROP_CNT_EN
    return CW'(drops);
`else
    return '0;
`endif
  endfunction
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outputs", {sig_ready, fault_timeout, fault_drop, state_o}, exp_out());
    check("drop_cnt", drop_cnt, exp_drops());
  endtask
  task automatic do_reset();
    #1 rst_n = 0;
    sig_in = 0; clr = 0;
    #1 check("rst_outputs", {sig_ready, fault_timeout, fault_drop, state_o, drop_cnt}, 0);
    m_reset();
    @(negedge clk) rst_n = 1;
  endtask
  task automatic wait_ready(string tag, int exp_n);
    n = 0;
    while (!sig_ready && n < 100) begin cycle(); n++; end
    check(tag, n, exp_n);
  endtask
  task automatic t_rise(string tag);
    repeat (5) cycle();
    sig_in = 1;
    wait_ready(tag, Q + 3);
    check({tag, "_st"}, {fault_timeout, fault_drop, state_o}, 4'b0010);
  endtask
  initial begin
    m_reset();
    do_reset();
    cycle();
    sig6 = 1;
    repeat (6) cycle();
    check("t6_early", r6, 1'b0);
    cycle();
    check("t6_ready", {r6, ft6, fd6, st6}, 5'b10010);
    do_reset();
    t_rise("t1_lat");
    sig_in = 0;
    repeat (2) cycle();
    check("t4_still_ready", sig_ready, 1'b1);
    cycle();
    check("t4_drop", {sig_ready, fault_drop, state_o}, 4'b0111);
    clr = 1;
    cycle();
    clr = 0;
    check("t4_clr", {fault_drop, fault_timeout, state_o}, 4'b0000);
    sig_in = 1;
    wait_ready("t4_requal", Q + 3);
    do_reset();
    t_rise("t5_lat");
    do_reset();
    n = 0;
    while (!fault_timeout && n < T + 50) begin cycle(); n++; end
    check("t2_tmo_edge", n, T);
    check("t2_st", {sig_ready, state_o}, 3'b011);
    do_reset();
    sig_in = 1;
    repeat (5) cycle();
    sig_in = 0;
    repeat (5) cycle();
    sig_in = 1;
    wait_ready("t3_lat", Q + 3);
`ifdef READY_MON_DROP_CNT_EN
    check("t3_drops", drop_cnt, 1);
`else
    check("t3_drops", drop_cnt, 0);
`endif
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int seg = 0; seg < 120; seg++) begin
        sig_in = $urandom_range(0, 1);
        for (int k = $urandom_range(1, 30); k > 0; k--) begin
          clr = $urandom_range(0, 150) == 0;
          cycle();
        end
        clr = 0;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
